// File: rtl/vec_pkg.sv
// Shared defaults and FSM state type for the vector writeback serializer.
package vec_pkg;
    localparam int LANES = 32;
    localparam int LANEW = 32;
    localparam int GROUP = 8;
    localparam int NGRP  = LANES / GROUP;
    localparam int GW    = (NGRP > 1) ? $clog2(NGRP) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;
endpackage

// File: rtl/grp_find.sv
// Combinational priority finder: lowest lane group at or above start whose mask slice is nonzero.
module grp_find #(
    parameter int LANES = 32,
    parameter int GROUP = 8,
    parameter int NGRP  = LANES / GROUP,
    parameter int GW    = (NGRP > 1) ? $clog2(NGRP) : 1
) (
    input  logic [LANES-1:0] mask,
    input  logic [GW:0]      start,
    output logic [GW-1:0]    idx,
    output logic             found
);
    // Descending scan so the last hit written is the lowest qualifying group;
    // start is one bit wider so start == NGRP means "nothing left".
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int g = NGRP - 1; g >= 0; g--) begin
            if (((GW+1)'(g) >= start) && (|mask[g*GROUP +: GROUP])) begin
                idx   = GW'(g);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/vec_wb_serializer.sv
// Serializes a captured vector result into per-group register-file writeback beats,
// skipping groups with no active lanes.
import vec_pkg::*;

module vec_wb_serializer #(
    parameter int LANES = vec_pkg::LANES,
    parameter int LANEW = vec_pkg::LANEW,
    parameter int GROUP = vec_pkg::GROUP,
    localparam int NGRP = LANES / GROUP,
    localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*LANEW-1:0] in_data,
    input  logic [LANES-1:0]       in_mask,
    input  logic [7:0]             in_dst,
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic [7:0]             wb_reg,
    output logic [GW-1:0]          wb_grp,
    output logic [GROUP*LANEW-1:0] wb_data,
    output logic [GROUP-1:0]       wb_mask,
    output logic                   done
);
    state_t                 state;
    logic [LANES*LANEW-1:0] data_q;
    logic [LANES-1:0]       mask_q;
    logic [7:0]             dst_q;

    logic [LANES*LANEW-1:0] src_data;
    logic [LANES-1:0]       src_mask;
    logic [GW:0]            start;
    logic [GW-1:0]          idx;
    logic                   found;
    logic [GROUP*LANEW-1:0] sel_data;
    logic [GROUP-1:0]       sel_mask;
    logic [GROUP*LANEW-1:0] beat_data;

    assign in_ready = (state == IDLE);

    // One finder serves both the first beat (straight off the inputs) and each successor beat.
    assign src_data = (state == IDLE) ? in_data : data_q;
    assign src_mask = (state == IDLE) ? in_mask : mask_q;
    assign start    = (state == IDLE) ? '0 : ({1'b0, wb_grp} + (GW+1)'(1));

    grp_find #(.LANES(LANES), .GROUP(GROUP), .NGRP(NGRP), .GW(GW)) u_find (
        .mask  (src_mask),
        .start (start),
        .idx   (idx),
        .found (found)
    );

    always_comb begin
        sel_data = '0;
        sel_mask = '0;
        for (int g = 0; g < NGRP; g++) begin
            if (idx == GW'(g)) begin
                sel_data = src_data[g*GROUP*LANEW +: GROUP*LANEW];
                sel_mask = src_mask[g*GROUP +: GROUP];
            end
        end
    end

    for (genvar l = 0; l < GROUP; l++) begin : g_lane
        assign beat_data[l*LANEW +: LANEW] = sel_mask[l] ? sel_data[l*LANEW +: LANEW] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            data_q   <= '0;
            mask_q   <= '0;
            dst_q    <= '0;
            wb_valid <= 1'b0;
            wb_reg   <= '0;
            wb_grp   <= '0;
            wb_data  <= '0;
            wb_mask  <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_q <= in_data;
                        mask_q <= in_mask;
                        dst_q  <= in_dst;
                        if (found) begin
                            state    <= DRAIN;
                            wb_valid <= 1'b1;
                            wb_reg   <= in_dst;
                            wb_grp   <= idx;
                            wb_data  <= beat_data;
                            wb_mask  <= sel_mask;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (wb_ready) begin
                        if (found) begin
                            wb_grp  <= idx;
                            wb_data <= beat_data;
                            wb_mask <= sel_mask;
                        end else begin
                            state    <= IDLE;
                            wb_valid <= 1'b0;
                            wb_data  <= '0;
                            wb_mask  <= '0;
                            done     <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vec_wb_serializer.sv
// Randomized bench for vec_wb_serializer against a queue-of-beats model, plus directed scenarios.
module tb_vec_wb_serializer;
    localparam int LANES = 32;
    localparam int LANEW = 32;
    localparam int GROUP = 8;
    localparam int NGRP  = LANES / GROUP;
    localparam int GW    = (NGRP > 1) ? $clog2(NGRP) : 1;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [LANES*LANEW-1:0] in_data = '0;
    logic [LANES-1:0]       in_mask = '0;
    logic [7:0]             in_dst = '0;
    logic                   wb_valid;
    logic                   wb_ready = 1'b1;
    logic [7:0]             wb_reg;
    logic [GW-1:0]          wb_grp;
    logic [GROUP*LANEW-1:0] wb_data;
    logic [GROUP-1:0]       wb_mask;
    logic                   done;

    always #5 clk = ~clk;

    vec_wb_serializer #(.LANES(LANES), .LANEW(LANEW), .GROUP(GROUP)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_mask(in_mask), .in_dst(in_dst),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_reg(wb_reg),
        .wb_grp(wb_grp), .wb_data(wb_data), .wb_mask(wb_mask), .done(done)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: a captured vector becomes a list of expected beats; the DUT is busy while it is non-empty.
    typedef struct {
        logic [7:0]             rg;
        int                     grp;
        logic [GROUP-1:0]       m;
        logic [GROUP*LANEW-1:0] d;
    } beat_t;

    beat_t q[$];
    bit    exp_done = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        beat_t b;
        if (!rst_n) begin
            q.delete();
            exp_done = 1'b0;
        end else begin
            exp_done = 1'b0;
            if (q.size() > 0) begin
                if (wb_ready) begin
                    void'(q.pop_front());
                    if (q.size() == 0) exp_done = 1'b1;
                end
            end else if (in_valid) begin
                for (int g = 0; g < NGRP; g++) begin
                    b.m = in_mask[g*GROUP +: GROUP];
                    if (b.m != 0) begin
                        b.rg  = in_dst;
                        b.grp = g;
                        for (int l = 0; l < GROUP; l++)
                            b.d[l*LANEW +: LANEW] = b.m[l] ? in_data[(g*GROUP+l)*LANEW +: LANEW] : '0;
                        q.push_back(b);
                    end
                end
                if (q.size() == 0) exp_done = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready", in_ready, q.size() == 0);
        chk("wb_valid", wb_valid, q.size() != 0);
        chk("done", done, exp_done);
        if (q.size() != 0) begin
            chk("wb_reg", wb_reg, q[0].rg);
            chk("wb_grp", wb_grp, q[0].grp);
            chk("wb_mask", wb_mask, q[0].m);
            chk("wb_data", wb_data, q[0].d);
        end else begin
            chk("wb_mask_idle", wb_mask, 0);
            chk("wb_data_idle", wb_data, 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic offer(input logic [LANES-1:0] m, input logic [7:0] dst);
        in_valid = 1'b1;
        in_mask  = m;
        in_dst   = dst;
        for (int i = 0; i < LANES; i++) in_data[i*LANEW +: LANEW] = 32'h1000_0000 + i;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (!in_ready && k < 40) begin step(); k++; end
        chk(name, in_ready, 1'b1);
    endtask

    function automatic logic [LANES-1:0] rand_mask();
        logic [LANES-1:0] m;
        if ($urandom_range(0, 9) == 0) return '0;
        for (int g = 0; g < NGRP; g++) begin
            case ($urandom_range(0, 2))
                0: m[g*GROUP +: GROUP] = '0;
                1: m[g*GROUP +: GROUP] = '1;
                default: m[g*GROUP +: GROUP] = GROUP'($urandom);
            endcase
        end
        return m;
    endfunction

    initial begin
        logic [GROUP*LANEW-1:0] snap_d;
        logic [GROUP-1:0]       snap_m;
        logic [GW-1:0]          snap_g;
        logic [7:0]             snap_r;
        bit                     seen;

        // Reset state
        @(negedge clk);
        chk("rst_wb_reg", wb_reg, 0);
        chk("rst_wb_grp", wb_grp, 0);
        chk("rst_done", done, 0);
        #2 rst_n = 1'b1;
        step();
        chk("rst_in_ready", in_ready, 1'b1);

        // Full mask: four back-to-back beats, done in cycle 5
        offer('1, 8'd5);
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k <= 4) begin
                chk("full_valid", wb_valid, 1'b1);
                chk("full_grp", wb_grp, k - 1);
                chk("full_mask", wb_mask, 8'hFF);
                chk("full_reg", wb_reg, 8'd5);
                chk("full_done_early", done, 1'b0);
            end else begin
                chk("full_done", done, 1'b1);
                chk("full_valid_end", wb_valid, 1'b0);
            end
        end
        step();

        // Sparse mask: groups 1 and 3 skipped
        offer(32'h00FF_0001, 8'd9);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("sparse_grp0", wb_grp, 0);
        chk("sparse_mask0", wb_mask, 8'h01);
        chk("sparse_lane0", wb_data[LANEW-1:0], 32'h1000_0000);
        chk("sparse_lanes1_7", wb_data[GROUP*LANEW-1:LANEW], 0);
        step();
        @(negedge clk);
        chk("sparse_grp2", wb_grp, 2);
        chk("sparse_mask2", wb_mask, 8'hFF);
        chk("sparse_lane16", wb_data[LANEW-1:0], 32'h1000_0010);
        step();
        @(negedge clk);
        chk("sparse_done", done, 1'b1);
        chk("sparse_valid_end", wb_valid, 1'b0);
        step();

        // Empty mask: no beats, immediate done
        offer('0, 8'd3);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("zero_done", done, 1'b1);
        chk("zero_valid", wb_valid, 1'b0);
        chk("zero_ready", in_ready, 1'b1);
        step();
        @(negedge clk);
        chk("zero_done_once", done, 1'b0);
        step();

        // Stall first beat for 3 cycles while another vector is offered
        offer('1, 8'd7);
        step();
        wb_ready = 1'b0;
        in_dst   = 8'd44;
        in_mask  = 32'h0000_00F0;
        @(negedge clk);
        snap_d = wb_data; snap_m = wb_mask; snap_g = wb_grp; snap_r = wb_reg;
        chk("stall_grp0", wb_grp, 0);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            chk("stall_data", wb_data, snap_d);
            chk("stall_mask", wb_mask, snap_m);
            chk("stall_grp", wb_grp, snap_g);
            chk("stall_reg", wb_reg, 8'd7);
            chk("stall_in_ready", in_ready, 1'b0);
            step();
        end
        wb_ready = 1'b1;
        in_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else chk("stall_reg_kept", wb_reg, snap_r);
            step();
        end
        chk("stall_done_seen", seen, 1'b1);
        wait_idle("stall_idle");

        // Reset during the second of four beats
        offer('1, 8'd11);
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", wb_valid, 1'b0);
        chk("mid_rst_data", wb_data, 0);
        chk("mid_rst_grp", wb_grp, 0);
        chk("mid_rst_done", done, 1'b0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_no_done", done, 1'b0);
            step();
        end
        offer('1, 8'd12);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_grp0", wb_grp, 0);
        chk("post_rst_reg", wb_reg, 8'd12);
        wait_idle("post_rst_idle");

        // Randomized traffic with random backpressure
        for (int n = 0; n < 3000; n++) begin
            in_valid = ($urandom_range(0, 2) == 0);
            in_mask  = rand_mask();
            in_dst   = 8'($urandom);
            for (int i = 0; i < LANES; i++) in_data[i*LANEW +: LANEW] = $urandom;
            wb_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = 1'b0;
        wb_ready = 1'b1;
        wait_idle("final_idle");
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/vec_wb_serializer.md
VEC_WB_SERIALIZER -- requirements
Module: vec_wb_serializer

Interface
REQ-001 The block SHALL have parameter LANES, default 32, meaning warp width in lanes.
REQ-002 The block SHALL have parameter LANEW, default 32, meaning lane bit width.
REQ-003 The block SHALL have parameter GROUP, default 8, meaning lanes per writeback beat; LANES SHALL be a multiple of GROUP. NGRP = LANES/GROUP; GW = max(1, clog2(NGRP)).
REQ-004 The block SHALL use reset rst_n, asynchronous, active-low, and clock clk.
REQ-005 The port list SHALL be:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- in_valid  in  1  vector result offered
- in_ready  out  1  block can accept a vector
- in_data  in  LANES*LANEW  flat result; lane i at [i*LANEW +: LANEW]
- in_mask  in  LANES  per-lane active mask
- in_dst  in  8  destination vector register index
- wb_valid  out  1  writeback beat valid
- wb_ready  in  1  register file accepts beat
- wb_reg  out  8  destination register of beat
- wb_grp  out  GW  lane-group index of beat
- wb_data  out  GROUP*LANEW  group lane data
- wb_mask  out  GROUP  group lane write enables
- done  out  1  one-cycle pulse, vector fully written back

Function
REQ-006 The block SHALL implement states IDLE and DRAIN; in_ready SHALL equal 1 exactly in IDLE.
REQ-007 When in_valid && in_ready, the block SHALL capture in_data, in_mask and in_dst into internal registers.
REQ-008 If the captured in_mask is all zero, the block SHALL stay in IDLE, emit no beat, and pulse done in the next cycle.
REQ-009 Otherwise the block SHALL enter DRAIN and assert wb_valid in the cycle after capture, presenting the lowest-index group with a nonzero mask slice.
REQ-010 The block SHALL emit beats only for groups with a nonzero mask slice, in ascending group order; it SHALL skip all-zero groups without idle cycles.
REQ-011 A beat for group g SHALL present wb_grp = g, wb_reg = captured dst, wb_mask = mask[g*GROUP +: GROUP], and wb_data lanes = captured data where the mask bit is 1, else 0.
REQ-012 While wb_valid && !wb_ready, all wb_* outputs SHALL remain stable.
REQ-013 On wb_valid && wb_ready, the block SHALL either present the next active group in the following cycle, or, if none remains, deassert wb_valid, pulse done for one cycle, and return to IDLE.
REQ-014 With wb_ready held at 1, a vector with K active groups SHALL take exactly K beat cycles; done SHALL assert in the cycle after the last handshake.
REQ-015 in_valid SHALL be ignored outside IDLE; there SHALL be no capture in the same cycle as the final handshake.
REQ-016 Outside DRAIN, wb_valid, wb_mask and wb_data SHALL be 0.

Reset
REQ-017 On rst_n low, the block SHALL enter IDLE and clear in its capture registers, wb_valid, wb_reg, wb_grp, wb_data, wb_mask and done to 0; in_ready SHALL be 1 after reset release.
REQ-018 Reset asserted mid-DRAIN SHALL discard the in-flight vector with no done pulse.

Structure
REQ-019 The shared package vec_pkg SHALL hold LANES, LANEW, GROUP, NGRP and GW defaults and the state enum (IDLE, DRAIN).
REQ-020 The next-group search SHALL be the sub-module grp_find: a combinational priority finder returning the lowest nonzero group index >= a start index, plus a found flag.

Verification
REQ-021 The bench SHALL cover: mask=0xFFFFFFFF, dst=5, wb_ready=1 -> 4 consecutive beats with grp 0,1,2,3, wb_mask=0xFF, done in cycle 5 after capture.
REQ-022 The bench SHALL cover: mask=0x00FF0001 -> beats grp 0 (wb_mask=0x01, lanes 1..7 data 0) then grp 2 (wb_mask=0xFF); groups 1 and 3 are skipped; done after 2 beats.
REQ-023 The bench SHALL cover: mask=0 -> no wb_valid, done pulses the cycle after capture, in_ready stays 1.
REQ-024 The bench SHALL cover: wb_ready=0 for 3 cycles on the first beat -> wb_* outputs are stable for those cycles, and in_valid offered meanwhile gets in_ready=0 and no capture.
REQ-025 The bench SHALL cover: rst_n pulsed low during the second of 4 beats -> outputs cleared, no done, next vector drains correctly from grp 0.
